// File: rtl/spi_ram_ctrl_p.sv
// SPI-side command decoder for a single-port RAM.
// Decodes framed {opcode, payload} words into pointer loads, writes and reads.
// Optional pointer post-increment supports burst access.
// Read data goes to the SPI transmit path through a tx_valid/tx_ready handshake.
// A sticky flag records any read that was dropped because of backpressure.
module spi_ram_ctrl_p #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              rd_ovf,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr
);

  localparam int  DEPTH   = 1 << ADDR_W;
  localparam bit  INC_ON  = (AUTO_INC != 0);

  localparam logic [1:0] OP_SET_WR = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SET_RD = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic              cmd_set_wr;
  logic              cmd_write;
  logic              cmd_set_rd;
  logic              cmd_read;
  logic              read_accept;
  logic              read_drop;
  logic [ADDR_W-1:0] wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_next;

  assign opcode  = din[DATA_W+1:DATA_W];
  assign payload = din[DATA_W-1:0];

  assign cmd_set_wr = rx_valid && (opcode == OP_SET_WR);
  assign cmd_write  = rx_valid && (opcode == OP_WRITE);
  assign cmd_set_rd = rx_valid && (opcode == OP_SET_RD);
  assign cmd_read   = rx_valid && (opcode == OP_READ);

  // A read is only taken when the output slot is free or drains on this edge
  assign read_accept = cmd_read && (!tx_valid || tx_ready);
  assign read_drop   = cmd_read && tx_valid && !tx_ready;

  // Next-pointer selection: address loads, optional post-increment with natural wrap
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (cmd_set_wr) begin
      wr_ptr_next = payload[ADDR_W-1:0];
    end else if (cmd_write && INC_ON) begin
      wr_ptr_next = wr_ptr + ADDR_W'(1);
    end
    if (cmd_set_rd) begin
      rd_ptr_next = payload[ADDR_W-1:0];
    end else if (read_accept && INC_ON) begin
      rd_ptr_next = rd_ptr + ADDR_W'(1);
    end
  end

  // Memory write port; contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!rst && cmd_write) begin
      mem[wr_ptr] <= payload;
    end
  end

  // Pointers, registered read data, handshake and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      tx_valid <= 1'b0;
      rd_ovf   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      if (read_accept) begin
        dout     <= mem[rd_ptr];
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (read_drop) begin
        rd_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl_p.sv
// Scoreboard bench for spi_ram_ctrl_p: one auto-increment 8/8 instance and one
// non-incrementing 4-bit-address / 16-bit-data instance share a clock and reset.
module tb_spi_ram_ctrl_p;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: ADDR_W=8, DATA_W=8, AUTO_INC=1
  logic        rx_valid_a;
  logic [9:0]  din_a;
  logic        tx_ready_a;
  logic [7:0]  dout_a;
  logic        tx_valid_a;
  logic        rd_ovf_a;
  logic [7:0]  wr_ptr_a;
  logic [7:0]  rd_ptr_a;

  // Instance B: ADDR_W=4, DATA_W=16, AUTO_INC=0
  logic        rx_valid_b;
  logic [17:0] din_b;
  logic        tx_ready_b;
  logic [15:0] dout_b;
  logic        tx_valid_b;
  logic        rd_ovf_b;
  logic [3:0]  wr_ptr_b;
  logic [3:0]  rd_ptr_b;

  spi_ram_ctrl_p #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(1)) dut_a (
    .clk(clk), .rst(rst), .rx_valid(rx_valid_a), .din(din_a), .tx_ready(tx_ready_a),
    .dout(dout_a), .tx_valid(tx_valid_a), .rd_ovf(rd_ovf_a),
    .wr_ptr(wr_ptr_a), .rd_ptr(rd_ptr_a)
  );

  spi_ram_ctrl_p #(.ADDR_W(4), .DATA_W(16), .AUTO_INC(0)) dut_b (
    .clk(clk), .rst(rst), .rx_valid(rx_valid_b), .din(din_b), .tx_ready(tx_ready_b),
    .dout(dout_b), .tx_valid(tx_valid_b), .rd_ovf(rd_ovf_b),
    .wr_ptr(wr_ptr_b), .rd_ptr(rd_ptr_b)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q_a [$];
  logic [15:0] exp_q_b [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitors: every completed handshake pops and compares one expected word
  always @(negedge clk) begin
    if (rst === 1'b0 && tx_valid_a === 1'b1 && tx_ready_a === 1'b1) begin
      total++;
      if (exp_q_a.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected_output: got 0x%0h expected none", dout_a);
      end else begin
        logic [7:0] e;
        e = exp_q_a.pop_front();
        if (dout_a !== e) begin
          bad++;
          $display("FAIL a_read_data: got 0x%0h expected 0x%0h", dout_a, e);
        end else begin
          $display("ok   a_read_data: 0x%0h", dout_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && tx_valid_b === 1'b1 && tx_ready_b === 1'b1) begin
      total++;
      if (exp_q_b.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected_output: got 0x%0h expected none", dout_b);
      end else begin
        logic [15:0] e;
        e = exp_q_b.pop_front();
        if (dout_b !== e) begin
          bad++;
          $display("FAIL b_read_data: got 0x%0h expected 0x%0h", dout_b, e);
        end else begin
          $display("ok   b_read_data: 0x%0h", dout_b);
        end
      end
    end
  end

  // Each command occupies exactly one edge; callers sit at posedge+1
  task automatic cmd_a(input logic [1:0] op, input logic [7:0] pl);
    rx_valid_a = 1'b1;
    din_a      = {op, pl};
    @(posedge clk); #1;
    rx_valid_a = 1'b0;
    din_a      = '0;
  endtask

  task automatic cmd_b(input logic [1:0] op, input logic [15:0] pl);
    rx_valid_b = 1'b1;
    din_b      = {op, pl};
    @(posedge clk); #1;
    rx_valid_b = 1'b0;
    din_b      = '0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rx_valid_a = 1'b0; din_a = '0; tx_ready_a = 1'b0;
    rx_valid_b = 1'b0; din_b = '0; tx_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_dout",     32'(dout_a),     32'h0);
    chk("rst_tx_valid", 32'(tx_valid_a), 32'h0);
    chk("rst_rd_ovf",   32'(rd_ovf_a),   32'h0);
    chk("rst_wr_ptr",   32'(wr_ptr_a),   32'h0);
    chk("rst_rd_ptr",   32'(rd_ptr_a),   32'h0);

    // Basic write then read
    tx_ready_a = 1'b1;
    cmd_a(2'b00, 8'h10);
    cmd_a(2'b01, 8'hA5);
    chk("t1_wr_ptr_inc", 32'(wr_ptr_a), 32'h11);
    cmd_a(2'b10, 8'h10);
    exp_q_a.push_back(8'hA5);
    cmd_a(2'b11, 8'h00);
    chk("t1_tx_valid_up", 32'(tx_valid_a), 32'h1);
    chk("t1_rd_ptr_inc",  32'(rd_ptr_a),   32'h11);
    idle();
    chk("t1_tx_valid_down", 32'(tx_valid_a), 32'h0);

    // Auto-increment wrap on writes and reads
    cmd_a(2'b00, 8'hFE);
    cmd_a(2'b01, 8'h11);
    cmd_a(2'b01, 8'h22);
    cmd_a(2'b01, 8'h33);
    chk("t2_wr_ptr_wrap", 32'(wr_ptr_a), 32'h01);
    cmd_a(2'b10, 8'hFF);
    exp_q_a.push_back(8'h22);
    cmd_a(2'b11, 8'h00);
    idle();
    exp_q_a.push_back(8'h33);
    cmd_a(2'b11, 8'h00);
    chk("t2_rd_ptr_wrap", 32'(rd_ptr_a), 32'h01);
    idle();

    // Backpressure: hold, drop a second read, then drain
    tx_ready_a = 1'b0;
    cmd_a(2'b10, 8'h10);
    exp_q_a.push_back(8'hA5);
    cmd_a(2'b11, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(tx_valid_a), 32'h1);
      chk("t3_hold_dout",  32'(dout_a),     32'hA5);
      idle();
    end
    chk("t3_ovf_before", 32'(rd_ovf_a), 32'h0);
    cmd_a(2'b11, 8'h00);
    chk("t3_ovf_set",       32'(rd_ovf_a), 32'h1);
    chk("t3_rd_ptr_kept",   32'(rd_ptr_a), 32'h11);
    chk("t3_dout_kept",     32'(dout_a),   32'hA5);
    chk("t3_valid_kept",    32'(tx_valid_a), 32'h1);
    tx_ready_a = 1'b1;
    idle();
    chk("t3_valid_drained", 32'(tx_valid_a), 32'h0);
    chk("t3_ovf_sticky",    32'(rd_ovf_a),   32'h1);

    // Back-to-back reads with no bubble
    cmd_a(2'b10, 8'hFE);
    exp_q_a.push_back(8'h11);
    cmd_a(2'b11, 8'h00);
    exp_q_a.push_back(8'h22);
    cmd_a(2'b11, 8'h00);
    chk("t4_valid_stays", 32'(tx_valid_a), 32'h1);
    chk("t4_dout_next",   32'(dout_a),     32'h22);
    idle();
    chk("t4_valid_down",  32'(tx_valid_a), 32'h0);

    // Non-incrementing wide instance
    cmd_b(2'b00, 16'hFFF3);
    chk("t5_wr_ptr_trunc", 32'(wr_ptr_b), 32'h3);
    cmd_b(2'b01, 16'hBEEF);
    cmd_b(2'b01, 16'hBEEF);
    chk("t5_wr_ptr_fixed", 32'(wr_ptr_b), 32'h3);
    cmd_b(2'b10, 16'h0003);
    exp_q_b.push_back(16'hBEEF);
    cmd_b(2'b11, 16'h0000);
    chk("t5_rd_ptr_fixed", 32'(rd_ptr_b), 32'h3);
    chk("t5_tx_valid",     32'(tx_valid_b), 32'h1);
    idle();

    // Reset while stalled with overflow set; memory survives
    tx_ready_a = 1'b0;
    cmd_a(2'b10, 8'h00);
    cmd_a(2'b11, 8'h00);
    chk("t6_pre_valid", 32'(tx_valid_a), 32'h1);
    chk("t6_pre_ovf",   32'(rd_ovf_a),   32'h1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("t6_dout",     32'(dout_a),     32'h0);
    chk("t6_tx_valid", 32'(tx_valid_a), 32'h0);
    chk("t6_rd_ovf",   32'(rd_ovf_a),   32'h0);
    chk("t6_wr_ptr",   32'(wr_ptr_a),   32'h0);
    chk("t6_rd_ptr",   32'(rd_ptr_a),   32'h0);
    tx_ready_a = 1'b1;
    cmd_a(2'b10, 8'h10);
    exp_q_a.push_back(8'hA5);
    cmd_a(2'b11, 8'h00);
    idle();
    cmd_a(2'b10, 8'hFF);
    exp_q_a.push_back(8'h22);
    cmd_a(2'b11, 8'h00);
    idle();
    idle();

    chk("a_queue_drained", 32'(exp_q_a.size()), 32'h0);
    chk("b_queue_drained", 32'(exp_q_b.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
